// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the word-addressed PC, drives the instruction memory
// address and captures the returned instruction into the IF/ID pipeline register.
module fetch_unit #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_instr_i,
    output logic [DATA_W-1:0] ifid_instr_o,
    output logic [ADDR_W-1:0] ifid_pc_plus1_o,
    output logic              ifid_valid_o,
    output logic [31:0]       fetch_count_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic              redirect;

    // Wraps naturally at 2^ADDR_W because the sum is truncated to ADDR_W bits.
    assign pc_plus1 = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign redirect = jump_i | branch_taken_i;

    always_comb begin
        pc_d = pc_q;
        if (jump_i) begin
            pc_d = jump_target_i;
        end else if (branch_taken_i) begin
            pc_d = branch_target_i;
        end else if (!stall_i) begin
            pc_d = pc_plus1;
        end
    end

    // No delay slot: whatever is fetched in a redirect cycle is squashed to a bubble.
    always_comb begin
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus1_d = ifid_pc_plus1_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_count_d   = fetch_count_q;
        if (flush_i || redirect) begin
            ifid_instr_d    = '0;
            ifid_pc_plus1_d = '0;
            ifid_valid_d    = 1'b0;
        end else if (!stall_i) begin
            ifid_instr_d    = imem_instr_i;
            ifid_pc_plus1_d = pc_plus1;
            ifid_valid_d    = 1'b1;
            fetch_count_d   = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_instr_q    <= '0;
            ifid_pc_plus1_q <= '0;
            ifid_valid_q    <= 1'b0;
            fetch_count_q   <= '0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus1_q <= ifid_pc_plus1_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign imem_addr_o     = pc_q;
    assign ifid_instr_o    = ifid_instr_q;
    assign ifid_pc_plus1_o = ifid_pc_plus1_q;
    assign ifid_valid_o    = ifid_valid_q;
    assign fetch_count_o   = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed fetch/stall/redirect/wrap/reset steps followed by
// random control traffic, all checked against a cycle-level reference model.
module tb_fetch_unit;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall_i, flush_i, branch_taken_i, jump_i;
    logic [ADDR_W-1:0] branch_target_i, jump_target_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_instr_i;
    logic [DATA_W-1:0] ifid_instr_o;
    logic [ADDR_W-1:0] ifid_pc_plus1_o;
    logic              ifid_valid_o;
    logic [31:0]       fetch_count_o;

    logic [DATA_W-1:0] mem [DEPTH];

    // reference model state
    logic [ADDR_W-1:0] m_pc;
    logic [DATA_W-1:0] m_instr;
    logic [ADDR_W-1:0] m_pp1;
    logic              m_valid;
    logic [31:0]       m_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign imem_instr_i = mem[imem_addr_o];

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .imem_addr_o    (imem_addr_o),
        .imem_instr_i   (imem_instr_i),
        .ifid_instr_o   (ifid_instr_o),
        .ifid_pc_plus1_o(ifid_pc_plus1_o),
        .ifid_valid_o   (ifid_valid_o),
        .fetch_count_o  (fetch_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_instr = '0;
        m_pp1   = '0;
        m_valid = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic check_all(input string where);
        chk({where, ".imem_addr"},   32'(imem_addr_o),     32'(m_pc));
        chk({where, ".ifid_instr"},  ifid_instr_o,         m_instr);
        chk({where, ".ifid_pc_plus1"}, 32'(ifid_pc_plus1_o), 32'(m_pp1));
        chk({where, ".ifid_valid"},  32'(ifid_valid_o),    32'(m_valid));
        chk({where, ".fetch_count"}, fetch_count_o,        m_cnt);
    endtask

    // Drive one cycle of controls at the falling edge, let the rising edge happen,
    // advance the model from its pre-edge state, and check at the next falling edge.
    task automatic step(input bit st, input bit fl, input bit br, input logic [ADDR_W-1:0] bt,
                        input bit jp, input logic [ADDR_W-1:0] jt, input string where);
        logic [ADDR_W-1:0] old_pc;
        stall_i = st; flush_i = fl; branch_taken_i = br; branch_target_i = bt;
        jump_i = jp; jump_target_i = jt;
        @(posedge clk);
        old_pc = m_pc;
        if (fl || jp || br) begin
            m_instr = '0; m_pp1 = '0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = mem[old_pc];
            m_pp1   = ADDR_W'((int'(old_pc) + 1) % DEPTH);
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end
        if (jp)       m_pc = jt;
        else if (br)  m_pc = bt;
        else if (!st) m_pc = ADDR_W'((int'(old_pc) + 1) % DEPTH);
        @(negedge clk);
        check_all(where);
    endtask

    task automatic run(input string where);
        step(0, 0, 0, '0, 0, '0, where);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = 32'h2000_0000 + 32'(k);
        stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0;
        branch_target_i = '0; jump_target_i = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.imem_addr",   32'(imem_addr_o), 32'd0);
        chk("reset.ifid_instr",  ifid_instr_o, 32'h0);
        chk("reset.ifid_valid",  32'(ifid_valid_o), 32'd0);
        chk("reset.fetch_count", fetch_count_o, 32'd0);
        rst_n = 1'b1;

        // free run: words 0..3, then stall at pc=4
        for (int i = 0; i < 4; i++) begin
            run("free");
            chk("free.instr_seq", ifid_instr_o, 32'h2000_0000 + 32'(i));
            chk("free.pp1_seq",   32'(ifid_pc_plus1_o), 32'(i + 1));
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, '0, 0, '0, "stall");
            chk("stall.imem_addr",  32'(imem_addr_o), 32'd4);
            chk("stall.ifid_instr", ifid_instr_o, 32'h2000_0003);
            chk("stall.count",      fetch_count_o, 32'd4);
        end
        run("release");
        chk("release.ifid_instr", ifid_instr_o, 32'h2000_0004);
        run("free5");
        chk("six.instr", ifid_instr_o, 32'h2000_0005);
        chk("six.count", fetch_count_o, 32'd6);
        run("free6");
        chk("pc7", 32'(imem_addr_o), 32'd7);

        step(0, 0, 1, 10'd20, 0, '0, "branch");
        chk("branch.imem_addr", 32'(imem_addr_o), 32'd20);
        chk("branch.valid",     32'(ifid_valid_o), 32'd0);
        chk("branch.instr",     ifid_instr_o, 32'h0);
        run("after_branch");
        chk("after_branch.instr", ifid_instr_o, 32'h2000_0014);
        chk("after_branch.pp1",   32'(ifid_pc_plus1_o), 32'd21);

        step(1, 0, 1, 10'd50, 1, 10'd100, "jump_branch_stall");
        chk("jbs.imem_addr", 32'(imem_addr_o), 32'd100);
        chk("jbs.valid",     32'(ifid_valid_o), 32'd0);

        step(0, 0, 0, '0, 1, 10'd1023, "jump1023");
        chk("wrap.at1023", 32'(imem_addr_o), 32'd1023);
        run("wrap");
        chk("wrap.imem_addr", 32'(imem_addr_o), 32'd0);
        chk("wrap.instr",     ifid_instr_o, 32'h2000_03FF);
        chk("wrap.pp1",       32'(ifid_pc_plus1_o), 32'd0);

        // async reset mid-cycle at pc=9 with a valid IF/ID
        step(0, 0, 0, '0, 1, 10'd8, "jump8");
        run("to_pc9");
        chk("pre_rst.pc",    32'(imem_addr_o), 32'd9);
        chk("pre_rst.valid", 32'(ifid_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.pc",    32'(imem_addr_o), 32'd0);
        chk("async_rst.valid", 32'(ifid_valid_o), 32'd0);
        chk("async_rst.count", fetch_count_o, 32'd0);
        @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;
        run("resume");
        chk("resume.instr", ifid_instr_o, 32'h2000_0000);

        // random control traffic with random memory contents
        for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 30), ($urandom_range(99) < 10),
                 ($urandom_range(99) < 10), ADDR_W'($urandom),
                 ($urandom_range(99) < 5),  ADDR_W'($urandom), "rand");
            if ($urandom_range(99) < 2) begin
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                check_all("rand_rst");
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS core.
- Owns the program counter (PC) and drives the word address into instructionmemory, whose read is combinational.
- Captures the returned 32-bit Instruction into the IF/ID pipeline register for the decode stage.
- Handles stalls, branch/jump redirects and flush bubbles, and keeps a fetch counter for debug.

Parameters:
- ADDR_W, 10, PC / instruction-memory word-address width (1024 words).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  insert bubble into IF/ID this cycle.
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  ADDR_W  branch word address.
- jump  in  1  jump in ID.
- jump_target  in  ADDR_W  jump word address.
- imem_addr  out  ADDR_W  word address to instructionmemory Addr.
- imem_instr  in  DATA_W  Instruction returned by instructionmemory.
- ifid_instr  out  DATA_W  IF/ID instruction.
- ifid_pc_plus1  out  ADDR_W  IF/ID PC+1 of the captured instruction.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  out  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ifid_instr=0x00000000 (NOP), ifid_pc_plus1=0, ifid_valid=0, fetch_count=0.
- Reset deasserted mid-run restarts fetch at RESET_PC on the next edge; no partial state is retained.
- imem_addr = pc, combinational. Instruction memory is word-addressed: PC advances by 1, not 4.
- Latency: the instruction at address A appears on ifid_instr one rising edge after pc==A.
- Next-PC priority, highest first:
  - jump: pc <= jump_target.
  - branch_taken: pc <= branch_target.
  - stall: pc holds.
  - otherwise: pc <= pc+1.
- pc+1 wraps modulo 2^ADDR_W: 1023 -> 0 with the default ADDR_W.
- A redirect (jump or branch_taken) overrides stall: PC loads the target even when stall=1.
- No delay slot: the instruction fetched in the redirect cycle is squashed.
- IF/ID update, highest priority first:
  - flush or redirect: ifid_instr <= 0, ifid_valid <= 0, ifid_pc_plus1 <= 0.
  - stall: all IF/ID fields hold.
  - otherwise: ifid_instr <= imem_instr, ifid_pc_plus1 <= pc+1 (wrapped), ifid_valid <= 1.
- jump and branch_taken both high in the same cycle: jump wins, and the cycle counts as a single redirect.
- fetch_count increments by 1 on each edge where IF/ID loads with ifid_valid <= 1.
- fetch_count wraps 0xFFFFFFFF -> 0 and does not increment on stall, flush or redirect cycles.
- Targets are taken as-is. An out-of-range memory word returns whatever instructionmemory supplies, so no target checking is done here.
- All state is in a single clock domain. There are no combinational paths from stall/flush/redirect inputs to outputs, except imem_addr via pc.

Test Plan:
- Reset, then 6 free-running cycles with memory preloaded, word[k] = 0x20000000+k:
  - ifid_instr sequences 0x20000000..0x20000005.
  - ifid_pc_plus1 runs 1..6, ifid_valid goes 1 from the first edge.
  - fetch_count = 6.
- stall=1 for 3 cycles at pc=4:
  - pc and imem_addr stay 4, IF/ID holds word[3], fetch_count unchanged.
  - After release, word[4] loads on the next edge.
- branch_taken=1, branch_target=20 while pc=7:
  - Next cycle imem_addr=20 and ifid_valid=0 with ifid_instr=0.
  - The edge after that gives ifid_instr=word[20], ifid_pc_plus1=21.
- jump=1 with jump_target=100, and branch_taken=1 with branch_target=50, together with stall=1: pc goes to 100 and IF/ID is a bubble; jump wins and the redirect overrides stall.
- Force pc to 1023 via jump_target=1023, then run free: imem_addr sequence is 1023 -> 0, and ifid_pc_plus1 for word[1023] is 0.
- Assert rst_n=0 asynchronously mid-cycle while pc=9 and ifid_valid=1:
  - Outputs clear immediately, without waiting for a clock edge, to pc=0, ifid_valid=0, fetch_count=0.
  - After release, fetch resumes from word[0].
